// File: rtl/shift_reg_pkg.sv
// Shared types and decode helpers for the multi-lane universal shift register.
// Holds the mode/state enums plus the per-cycle data-operation selector.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    M_SISO_R = 3'b000,
    M_SISO_L = 3'b001,
    M_PISO_R = 3'b010,
    M_PIPO   = 3'b011,
    M_SIPO_R = 3'b100,
    M_ROT_R  = 3'b101,
    M_ROT_L  = 3'b110,
    M_HOLD   = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Data operation applied to the register on an enabled cycle.
  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_SER_R  = 3'd2,
    OP_SER_L  = 3'd3,
    OP_ZERO_R = 3'd4,
    OP_ROT_R  = 3'd5,
    OP_ROT_L  = 3'd6
  } op_e;

  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic logic is_right(input mode_e m);
    return m inside {M_SISO_R, M_PISO_R,
                     M_SIPO_R, M_ROT_R};
  endfunction

  function automatic logic can_load(
    input mode_e  m,
    input state_e s
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (m inside {M_SISO_R, M_SISO_L, M_PIPO,
                 M_ROT_R, M_ROT_L}): ok = 1'b1;
      (m == M_PISO_R):             ok = (s == IDLE);
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-shift data selector; a fired load always wins over a shift.
  function automatic op_e next_op(
    input mode_e  m,
    input state_e s,
    input logic   fire
  );
    op_e op;
    op = OP_HOLD;
    unique case (m)
      M_SISO_R: op = fire ? OP_LOAD : OP_SER_R;
      M_SISO_L: op = fire ? OP_LOAD : OP_SER_L;
      M_PISO_R: begin
        if (s == SHIFT) op = OP_ZERO_R;
        else if (fire)  op = OP_LOAD;
        else            op = OP_HOLD;
      end
      M_PIPO:   op = fire ? OP_LOAD : OP_HOLD;
      M_SIPO_R: op = OP_SER_R;
      M_ROT_R:  op = fire ? OP_LOAD : OP_ROT_R;
      M_ROT_L:  op = fire ? OP_LOAD : OP_ROT_L;
      M_HOLD:   op = OP_HOLD;
      default:  op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_beat_cnt.sv
// Beat counter shared by the PISO and SIPO word paths.
// Ports: clk, rst (sync, high), inc, clr -> cnt, last (current beat is final).
module shift_beat_cnt
  import shift_reg_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic [cnt_w(BEATS)-1:0] cnt,
  output logic                    last
);

  localparam int CW = cnt_w(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] base;

  // A clear in the same cycle makes this beat number zero,
  // so the beat taken alongside a clear is counted.
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc) begin
      cnt_d = (base == LAST) ? '0 : base + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (base == LAST);

endmodule

// File: rtl/shift_reg_multi.sv
// Universal shift register with LANES-wide serial lanes, beat counting,
// a parallel-load valid/ready handshake and word-complete pulses.
// Ports: clk, rst (sync, high), enable, mode[2:0], load_valid/load_ready,
//   parallel_in, ser_in -> ser_out, parallel_out, word_valid, shift_done,
//   busy; parity_out only when SHREG_PARITY_EN is defined.
module shift_reg_multi
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic [LANES-1:0] ser_in,
  output logic [LANES-1:0] ser_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             shift_done,
  output logic             busy
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = cnt_w(BEATS);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  state_e           state_q;
  state_e           state_d;
  logic [2:0]       mode_q;
  logic [2:0]       mode_d;
  logic             wv_q;
  logic             wv_d;
  logic             sd_q;
  logic             sd_d;

  mode_e            m;
  logic             mode_chg;
  state_e           st_eff;
  logic             fire;
  op_e              op;

  logic             piso_idle;
  logic             piso_run;
  logic             sipo;

  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             unused_cnt;

  assign m        = mode_e'(mode);
  assign mode_d   = mode;
  assign mode_chg = (mode != mode_q);

  // A mode switch abandons any word in flight: the FSM is
  // treated as IDLE for this cycle and the count restarts.
  assign st_eff = mode_chg ? IDLE : state_q;

  assign load_ready = !rst && enable
                      && can_load(m, st_eff);
  assign fire       = load_valid && load_ready;
  assign op         = next_op(m, st_eff, fire);

  assign piso_idle = (m == M_PISO_R)
                     && (st_eff == IDLE);
  assign piso_run  = (m == M_PISO_R)
                     && (st_eff == SHIFT);
  assign sipo      = (m == M_SIPO_R);

  assign cnt_clr = enable
                   && (mode_chg || (piso_idle && fire));
  assign cnt_inc = enable && (sipo || piso_run);

  shift_beat_cnt #(
    .BEATS(BEATS)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .cnt (cnt),
    .last(cnt_last)
  );

  assign unused_cnt = ^cnt;

  always_comb begin
    reg_d = reg_q;
    if (enable) begin
      case (op)
        OP_LOAD:
          reg_d = parallel_in;
        OP_SER_R:
          reg_d = {ser_in,
                   reg_q[WIDTH-1:LANES]};
        OP_SER_L:
          reg_d = {reg_q[WIDTH-1-LANES:0],
                   ser_in};
        OP_ZERO_R:
          reg_d = {{LANES{1'b0}},
                   reg_q[WIDTH-1:LANES]};
        OP_ROT_R:
          reg_d = {reg_q[LANES-1:0],
                   reg_q[WIDTH-1:LANES]};
        OP_ROT_L:
          reg_d = {reg_q[WIDTH-1-LANES:0],
                   reg_q[WIDTH-1:WIDTH-LANES]};
        default:
          reg_d = reg_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wv_d    = 1'b0;
    sd_d    = 1'b0;
    if (enable) begin
      state_d = st_eff;
      unique case (1'b1)
        piso_idle: begin
          if (fire) state_d = SHIFT;
        end
        piso_run: begin
          if (cnt_last) begin
            state_d = IDLE;
            sd_d    = 1'b1;
          end
        end
        sipo: begin
          wv_d = cnt_last;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q   <= '0;
      state_q <= IDLE;
      mode_q  <= 3'b000;
      wv_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      wv_q    <= wv_d;
      sd_q    <= sd_d;
    end
  end

`ifdef SHREG_PARITY_EN
  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (fire) begin
      par_d = ^parallel_in;
    end else if (wv_d) begin
      par_d = ^reg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_out = par_q;
`endif

  assign ser_out = is_right(m)
                   ? reg_q[LANES-1:0]
                   : reg_q[WIDTH-1:WIDTH-LANES];

  assign parallel_out = reg_q;
  assign word_valid   = wv_q;
  assign shift_done   = sd_q;
  assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_reg_multi.sv
// Vector/scoreboard bench for shift_reg_multi at WIDTH=8, LANES=2.
// Expected values are hand-derived constants per cycle.
module tb_shift_reg_multi;

  localparam int W = 8;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [2:0]   mode;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] parallel_in;
  logic [L-1:0] ser_in;
  logic [L-1:0] ser_out;
  logic [W-1:0] parallel_out;
  logic         word_valid;
  logic         shift_done;
  logic         busy;
`ifdef SHREG_PARITY_EN
  logic         parity_out;
`endif

  always #5 clk = ~clk;

  shift_reg_multi #(
    .WIDTH(W),
    .LANES(L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .parallel_in (parallel_in),
    .ser_in      (ser_in),
    .ser_out     (ser_out),
    .parallel_out(parallel_out),
    .word_valid  (word_valid),
    .shift_done  (shift_done),
    .busy        (busy)
`ifdef SHREG_PARITY_EN
    ,
    .parity_out  (parity_out)
`endif
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       lv;
    logic [7:0] pin;
    logic [1:0] sin;
    logic       lr;
    logic [7:0] po;
    logic [1:0] so;
    logic       wv;
    logic       sd;
    logic       bz;
    logic       par;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  function automatic vec_t v(
    input logic       r,
    input logic       en,
    input logic [2:0] md,
    input logic       lv,
    input logic [7:0] pin,
    input logic [1:0] sin,
    input logic       lr,
    input logic [7:0] po,
    input logic [1:0] so,
    input logic       wv,
    input logic       sd,
    input logic       bz,
    input logic       par
  );
    vec_t t;
    t.rst = r;   t.en = en;  t.mode = md;
    t.lv = lv;   t.pin = pin; t.sin = sin;
    t.lr = lr;   t.po = po;  t.so = so;
    t.wv = wv;   t.sd = sd;  t.bz = bz;
    t.par = par;
    return t;
  endfunction

  task automatic chk(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    rst         = t.rst;
    enable      = t.en;
    mode        = t.mode;
    load_valid  = t.lv;
    parallel_in = t.pin;
    ser_in      = t.sin;
    #1;
    chk("load_ready", {7'b0, load_ready}, {7'b0, t.lr});
    sb.push_back(t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard step %0d: got empty want entry",
               step);
    end else begin
      e = sb.pop_front();
      chk("parallel_out", parallel_out, e.po);
      chk("ser_out", {6'b0, ser_out}, {6'b0, e.so});
      chk("word_valid", {7'b0, word_valid}, {7'b0, e.wv});
      chk("shift_done", {7'b0, shift_done}, {7'b0, e.sd});
      chk("busy", {7'b0, busy}, {7'b0, e.bz});
`ifdef SHREG_PARITY_EN
      chk("parity_out", {7'b0, parity_out}, {7'b0, e.par});
`endif
    end
    step++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // reset with arbitrary inputs
    tbl.push_back(v(1,1,3'd3,1,8'hFF,2'd3, 0,8'h00,2'd0,0,0,0,0));
    tbl.push_back(v(1,1,3'd3,1,8'hFF,2'd3, 0,8'h00,2'd0,0,0,0,0));
    // PISO load 0xB4, requester holds valid
    tbl.push_back(v(0,1,3'd2,0,8'h00,2'd0, 1,8'h00,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd2,1,8'hB4,2'd0, 1,8'hB4,2'd0,0,0,1,0));
    tbl.push_back(v(0,1,3'd2,1,8'hB4,2'd0, 0,8'h2D,2'd1,0,0,1,0));
    tbl.push_back(v(0,1,3'd2,1,8'hB4,2'd0, 0,8'h0B,2'd3,0,0,1,0));
    tbl.push_back(v(0,1,3'd2,1,8'hB4,2'd0, 0,8'h02,2'd2,0,0,1,0));
    tbl.push_back(v(0,1,3'd2,0,8'h00,2'd0, 0,8'h00,2'd0,0,1,0,0));
    tbl.push_back(v(0,1,3'd2,0,8'h00,2'd0, 1,8'h00,2'd0,0,0,0,0));
    // SIPO two back-to-back words
    tbl.push_back(v(0,1,3'd4,1,8'hFF,2'd1, 0,8'h40,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd2, 0,8'h90,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd3, 0,8'hE4,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd0, 0,8'h39,2'd1,1,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd2, 0,8'h8E,2'd2,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd1, 0,8'h63,2'd3,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd3, 0,8'hD8,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd4,0,8'h00,2'd2, 0,8'hB6,2'd2,1,0,0,1));
    tbl.push_back(v(0,1,3'd7,1,8'h00,2'd0, 0,8'hB6,2'd2,0,0,0,1));
    // rotate left, SISO, PIPO, rotate right, enable low
    tbl.push_back(v(0,1,3'd6,1,8'h81,2'd0, 1,8'h81,2'd2,0,0,0,0));
    tbl.push_back(v(0,1,3'd6,0,8'h00,2'd0, 1,8'h06,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd6,0,8'h00,2'd0, 1,8'h18,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd0,0,8'h00,2'd3, 1,8'hC6,2'd2,0,0,0,0));
    tbl.push_back(v(0,1,3'd1,0,8'h00,2'd1, 1,8'h19,2'd0,0,0,0,0));
    tbl.push_back(v(0,1,3'd3,1,8'h5A,2'd0, 1,8'h5A,2'd1,0,0,0,0));
    tbl.push_back(v(0,1,3'd3,0,8'h00,2'd0, 1,8'h5A,2'd1,0,0,0,0));
    tbl.push_back(v(0,1,3'd5,0,8'h00,2'd0, 1,8'h96,2'd2,0,0,0,0));
    tbl.push_back(v(0,0,3'd5,1,8'h00,2'd0, 0,8'h96,2'd2,0,0,0,0));
    tbl.push_back(v(0,1,3'd3,1,8'h01,2'd0, 1,8'h01,2'd0,0,0,0,1));

    foreach (tbl[i]) apply(tbl[i]);

    // PISO with enable dropped for three cycles mid-word
    apply(v(0,1,3'd2,0,8'h00,2'd0, 1,8'h01,2'd1,0,0,0,1));
    apply(v(0,1,3'd2,1,8'hB4,2'd0, 1,8'hB4,2'd0,0,0,1,0));
    apply(v(0,1,3'd2,0,8'h00,2'd0, 0,8'h2D,2'd1,0,0,1,0));
    for (int k = 0; k < 3; k++) begin
      apply(v(0,0,3'd2,1,8'hB4,2'd0, 0,8'h2D,2'd1,0,0,1,0));
    end
    apply(v(0,1,3'd2,0,8'h00,2'd0, 0,8'h0B,2'd3,0,0,1,0));
    apply(v(0,1,3'd2,0,8'h00,2'd0, 0,8'h02,2'd2,0,0,1,0));
    apply(v(0,1,3'd2,0,8'h00,2'd0, 0,8'h00,2'd0,0,1,0,0));
    apply(v(0,1,3'd2,0,8'h00,2'd0, 1,8'h00,2'd0,0,0,0,0));

    // SIPO abandoned after 2 beats by rotate-right, then 4 fresh beats
    apply(v(0,1,3'd4,0,8'h00,2'd1, 0,8'h40,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd2, 0,8'h90,2'd0,0,0,0,0));
    apply(v(0,1,3'd5,0,8'h00,2'd3, 1,8'h24,2'd0,0,0,0,0));
    apply(v(0,1,3'd5,0,8'h00,2'd3, 1,8'h09,2'd1,0,0,0,0));
    apply(v(0,1,3'd5,0,8'h00,2'd3, 1,8'h42,2'd2,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd3, 0,8'hD0,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd0, 0,8'h34,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd1, 0,8'h4D,2'd1,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd3, 0,8'hD3,2'd3,1,0,0,1));
    apply(v(0,1,3'd7,0,8'h00,2'd0, 0,8'hD3,2'd3,0,0,0,1));

    // reset mid-word restarts the beat count
    apply(v(0,1,3'd4,0,8'h00,2'd1, 0,8'h74,2'd0,0,0,0,1));
    apply(v(1,1,3'd4,1,8'hFF,2'd3, 0,8'h00,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd1, 0,8'h40,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd2, 0,8'h90,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd3, 0,8'hE4,2'd0,0,0,0,0));
    apply(v(0,1,3'd4,0,8'h00,2'd0, 0,8'h39,2'd1,1,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_multi.md
Name: shift_reg_multi

Overview:
- Parametrised universal shift register with multi-bit serial lanes.
- Adds beat counting, a load valid/ready handshake and word-complete/shift-done pulses to the existing SISO/PISO/PIPO register style.
- Used as the serialiser/deserialiser stage between wide datapath registers and narrow serial links in the register flow.

Parameters:
- WIDTH, 128, register width in bits; must be a multiple of LANES.
- LANES, 1, serial bits moved per enabled cycle; 1 <= LANES < WIDTH.
- BEATS (localparam), WIDTH/LANES, shifts per full word.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  global cycle enable; low = full hold.
- mode  in  3  see Behaviour.
- load_valid  in  1  parallel load request.
- load_ready  out  1  block can accept a parallel load.
- parallel_in  in  WIDTH  parallel load data.
- ser_in  in  LANES  serial input lanes.
- ser_out  out  LANES  serial output lanes.
- parallel_out  out  WIDTH  register contents.
- word_valid  out  1  one-cycle pulse: SIPO word complete.
- shift_done  out  1  one-cycle pulse: PISO word fully emitted.
- busy  out  1  state == SHIFT.

Behaviour:
- Reset (rst=1 at posedge): reg=0, cnt=0, state=IDLE, mode_q=000, word_valid=0, shift_done=0. Reset overrides every other input, including mid-word.
- Modes:
  - 000 SISO right: reg={ser_in, reg[WIDTH-1:LANES]}
  - 001 SISO left: reg={reg[WIDTH-1-LANES:0], ser_in}
  - 010 PISO right
  - 011 PIPO
  - 100 SIPO right
  - 101 rotate right by LANES
  - 110 rotate left by LANES
  - 111 hold
- ser_out: reg[LANES-1:0] for right modes (000, 010, 100, 101); reg[WIDTH-1:WIDTH-LANES] for the others.
- enable=0: reg, cnt, state frozen; load_ready=0; word_valid=0; shift_done=0.
- Handshake: a load fires when load_valid && load_ready at posedge.
  - load_ready = enable && (mode in {000,001,011,101,110}, or mode==010 with state==IDLE).
  - load_ready = 0 for modes 100 and 111.
- Modes 000/001/101/110: shift every enabled cycle. A fired load replaces that cycle's shift. No counting; state stays IDLE.
- Mode 011: a fired load writes parallel_in; otherwise hold.
- Mode 010 PISO FSM:
  - IDLE: a fired load sets reg=parallel_in, cnt=0, state=SHIFT.
  - SHIFT: each enabled cycle does reg={LANES'b0, reg[WIDTH-1:LANES]} and cnt++.
  - On the shift with cnt==BEATS-1: state=IDLE, cnt=0, shift_done=1 on the following cycle.
  - load_valid in SHIFT is not accepted; the requester must hold it until load_ready.
  - The first LANES bits are visible on ser_out the cycle after the load.
- Mode 100 SIPO:
  - Each enabled cycle does reg={ser_in, reg[WIDTH-1:LANES]} and cnt++.
  - On the shift with cnt==BEATS-1: cnt wraps to 0 and word_valid=1 the next cycle, with parallel_out holding the complete word for that cycle.
  - Back-to-back words need no gap.
- Mode change: mode_q registers mode every cycle. If mode != mode_q: cnt=0 and state=IDLE that cycle (the partial word is abandoned, no pulse). The new mode's data operation still applies in the same cycle.
- word_valid and shift_done are registered; they are never asserted together.
- cnt width: $clog2(BEATS), minimum 1. For BEATS==1 every shift completes a word.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined:
  - Adds output parity_out (1 bit), the even parity (XOR reduction) of parallel_in on each fired load, or of the completed word on the word_valid cycle.
  - Registered; reset 0; holds otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shift_reg_pkg:
  - mode_e enum (3 bits, values above).
  - state_e enum {IDLE, SHIFT}.
  - Helper function for next-shift data.
- One sub-module: shift_beat_cnt (parametrised BEATS). Inputs: inc, clr. Outputs: cnt, last = (cnt==BEATS-1). Used by both PISO and SIPO paths.

Test Plan (WIDTH=8, LANES=2, BEATS=4 unless stated):
- Reset: rst=1 for 2 cycles with arbitrary inputs -> parallel_out=0x00, word_valid=0, shift_done=0, busy=0, load_ready=0 during reset.
- PISO: mode=010, load 0xB4 -> ser_out 00,01,11,10 on 4 consecutive enabled cycles; busy=1 throughout; shift_done pulses 1 cycle after the 4th shift; load_ready=0 while busy.
- SIPO: mode=100, ser_in 2'b01,10,11,00 -> word_valid one cycle after the 4th shift with parallel_out=0x39; the next 4 beats produce a second pulse with no gap.
- Enable gating: PISO mid-word, enable=0 for 3 cycles -> ser_out, cnt and busy frozen; resumes and completes with exactly 4 total shifts.
- Mode change mid-word: SIPO after 2 beats switches to 101 -> no word_valid; the register rotates right by 2 each cycle; returning to 100 needs 4 fresh beats.
- Rotate and parity: mode=110, load 0x81 -> next cycle 0x06, then 0x18. With SHREG_PARITY_EN, parity_out=0 after load 0x81 and 1 after load 0x01.
